// File: rtl/isa_issue_ctrl_pkg.sv
// Shared definitions for the in-order issue controller:
//   opcode values, instruction field positions, FSM state encoding,
//   scoreboard entry layout and an opcode-class decoder.
package isa_issue_ctrl_pkg;

  localparam logic [6:0] OP_NOP  = 7'd0;
  localparam logic [6:0] OP_LOAD = 7'd1;
  localparam logic [6:0] OP_ADD  = 7'd2;

  // Instruction field bit positions: [15:9] opcode, [8:6] dest, [5:3] src2, [2:0] src1
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 9;
  localparam int unsigned DST_MSB  = 8;
  localparam int unsigned DST_LSB  = 6;
  localparam int unsigned SRC2_MSB = 5;
  localparam int unsigned SRC2_LSB = 3;
  localparam int unsigned SRC1_MSB = 2;
  localparam int unsigned SRC1_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_LOAD,
    CLS_ADD
  } op_class_t;

  typedef struct packed {
    logic       v;
    logic [2:0] adr;
  } sb_entry_t;

  // Anything that is not LOAD or ADD behaves as a NOP: reads and writes nothing.
  function automatic op_class_t decode_class(input logic [6:0] opc);
    op_class_t cls;
    case (opc)
      OP_NOP:  cls = CLS_NOP;
      OP_LOAD: cls = CLS_LOAD;
      OP_ADD:  cls = CLS_ADD;
      default: cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/isa_scoreboard.sv
// In-flight destination register scoreboard.
//   PIPE_DEPTH entries {v, adr}, shifted every cycle; the oldest falls off.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, push_adr  enter a valid entry for push_adr at sb[0] (else sb[0] <= invalid)
//   rd0_en/rd0_adr  read port 0 (compared against every valid entry)
//   rd1_en/rd1_adr  read port 1
//   hit             an enabled read port matches a valid entry
//   empty           no valid entry present
module isa_scoreboard
  import isa_issue_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [2:0] push_adr,
  input  logic       rd0_en,
  input  logic [2:0] rd0_adr,
  input  logic       rd1_en,
  input  logic [2:0] rd1_adr,
  output logic       hit,
  output logic       empty
);

  sb_entry_t sb [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      sb[0] <= push ? '{v: 1'b1, adr: push_adr} : '0;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  always_comb begin
    hit   = 1'b0;
    empty = 1'b1;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (sb[k].v) begin
        empty = 1'b0;
        if ((rd0_en && (sb[k].adr == rd0_adr)) || (rd1_en && (sb[k].adr == rd1_adr))) begin
          hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/isa_issue_ctrl.sv
// In-order issue controller in front of the 3-stage ISA pipeline.
//   Accepts 16-bit instructions over valid/ready, holds back RAW-dependent
//   instructions (issuing NOP bubbles meanwhile), supports a drain sequence
//   and keeps issue/stall statistics.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   in_valid, in_ins  instruction source; in_ready accepts (combinational)
//   flush             request drain: stop accepting until scoreboard empty
//   pipe_ins          registered instruction to fetch register (0 = bubble)
//   pipe_valid        pipe_ins carries a real accepted instruction
//   flush_done        high for the single DRAIN cycle in which the scoreboard is empty
//   busy              scoreboard holds at least one valid entry
//   state             0=RUN, 1=STALL, 2=DRAIN
//   issue_cnt         transfers, wrapping
//   stall_cnt         hazard cycles outside DRAIN, saturating
module isa_issue_ctrl
  import isa_issue_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_ins,
  output logic             in_ready,
  input  logic             flush,
  output logic [15:0]      pipe_ins,
  output logic             pipe_valid,
  output logic             flush_done,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t    state_q, state_d;
  op_class_t cls;
  logic      rd_src1, rd_src2, writes;
  logic      sb_hit, sb_empty;
  logic      hazard, xfer;

  // Opcode decode
  assign cls     = decode_class(in_ins[OPC_MSB:OPC_LSB]);
  assign rd_src1 = (cls == CLS_ADD);
  assign rd_src2 = (cls == CLS_ADD) || (cls == CLS_LOAD);
  assign writes  = (cls != CLS_NOP);

  // The incoming word's own dest is only pushed on transfer, so a
  // self-dependency is compared against older entries only.
  isa_scoreboard #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .push     (xfer && writes),
    .push_adr (in_ins[DST_MSB:DST_LSB]),
    .rd0_en   (in_valid && rd_src1),
    .rd0_adr  (in_ins[SRC1_MSB:SRC1_LSB]),
    .rd1_en   (in_valid && rd_src2),
    .rd1_adr  (in_ins[SRC2_MSB:SRC2_LSB]),
    .hit      (sb_hit),
    .empty    (sb_empty)
  );

  assign hazard = sb_hit;
  assign xfer   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush)       state_d = ST_DRAIN;
        else if (hazard) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (flush)        state_d = ST_DRAIN;
        else if (!hazard) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (sb_empty) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state_q != ST_DRAIN) && !flush && !hazard;
    flush_done = (state_q == ST_DRAIN) && sb_empty;
  end

  assign state = state_q;
  assign busy  = !sb_empty;

  // Issue register and statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_ins   <= '0;
      pipe_valid <= 1'b0;
      issue_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      pipe_ins   <= xfer ? in_ins : '0;
      pipe_valid <= xfer;
      if (xfer) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (hazard && (state_q != ST_DRAIN) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isa_issue_ctrl.sv
// Directed self-checking bench for isa_issue_ctrl (PIPE_DEPTH=2, CNT_W=4).
module tb_isa_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_ins;
  logic        in_ready;
  logic        flush;
  logic [15:0] pipe_ins;
  logic        pipe_valid;
  logic        flush_done;
  logic        busy;
  logic [1:0]  state;
  logic [3:0]  issue_cnt;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  isa_issue_ctrl #(
    .PIPE_DEPTH(2),
    .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ins     (in_ins),
    .in_ready   (in_ready),
    .flush      (flush),
    .pipe_ins   (pipe_ins),
    .pipe_valid (pipe_valid),
    .flush_done (flush_done),
    .busy       (busy),
    .state      (state),
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_ins   = 16'h0000;
    step();
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset held 2 cycles with in_valid=1
    rst      = 1'b0;
    in_valid = 1'b1;
    in_ins   = 16'h0250;
    flush    = 1'b0;
    step();
    step();
    chk("rst_pipe_valid", pipe_valid, 0);
    chk("rst_pipe_ins",   pipe_ins,   0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_issue_cnt",  issue_cnt,  0);
    chk("rst_stall_cnt",  stall_cnt,  0);
    chk("rst_state",      state,      0);
    rst      = 1'b1;
    in_valid = 1'b0;
    settle();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_state",    state,    0);

    // 2: independent back-to-back stream
    in_valid = 1'b1;
    in_ins   = 16'h0250;
    settle();
    chk("ind_ready0", in_ready, 1);
    step();
    chk("ind_pipe_ins0",   pipe_ins,   16'h0250);
    chk("ind_pipe_valid0", pipe_valid, 1);
    in_ins = 16'h0513;
    settle();
    chk("ind_ready1", in_ready, 1);
    step();
    chk("ind_pipe_ins1",   pipe_ins,   16'h0513);
    chk("ind_pipe_valid1", pipe_valid, 1);
    chk("ind_issue_cnt",   issue_cnt,  2);
    chk("ind_stall_cnt",   stall_cnt,  0);
    in_valid = 1'b0;
    step();
    chk("ind_idle_valid", pipe_valid, 0);
    chk("ind_idle_ins",   pipe_ins,   0);

    // 3: RAW hazard LOAD R1 -> ADD R3,R1,R2
    do_reset();
    in_valid = 1'b1;
    in_ins   = 16'h0250;
    step();
    chk("raw_prod_valid", pipe_valid, 1);
    in_ins = 16'h04D1;
    settle();
    chk("raw_ready_c1", in_ready, 0);
    step();
    chk("raw_bubble1_ins",   pipe_ins,   0);
    chk("raw_bubble1_valid", pipe_valid, 0);
    chk("raw_state_stall1",  state,      1);
    settle();
    chk("raw_ready_c2", in_ready, 0);
    step();
    chk("raw_bubble2_ins",  pipe_ins, 0);
    chk("raw_state_stall2", state,    1);
    settle();
    chk("raw_ready_c3", in_ready, 1);
    step();
    chk("raw_issue_ins",   pipe_ins,   16'h04D1);
    chk("raw_issue_valid", pipe_valid, 1);
    chk("raw_state_run",   state,      0);
    chk("raw_stall_cnt",   stall_cnt,  2);
    chk("raw_issue_cnt",   issue_cnt,  2);
    in_valid = 1'b0;

    // 4: flush with two in-flight writers and a pending independent word
    do_reset();
    in_valid = 1'b1;
    in_ins   = 16'h0250;
    step();
    in_ins = 16'h0513;
    step();
    in_ins = 16'h0370;
    flush  = 1'b1;
    settle();
    chk("fl_ready_flush", in_ready, 0);
    chk("fl_busy0",       busy,     1);
    step();
    flush = 1'b0;
    chk("fl_state_drain1", state,      2);
    chk("fl_no_issue",     pipe_valid, 0);
    chk("fl_busy1",        busy,       1);
    chk("fl_done0",        flush_done, 0);
    chk("fl_issue_cnt0",   issue_cnt,  2);
    settle();
    chk("fl_ready_drain", in_ready, 0);
    step();
    chk("fl_state_drain2", state,      2);
    chk("fl_busy2",        busy,       0);
    chk("fl_done1",        flush_done, 1);
    step();
    chk("fl_state_run", state,      0);
    chk("fl_done2",     flush_done, 0);
    chk("fl_still_no",  pipe_valid, 0);
    settle();
    chk("fl_ready_run", in_ready, 1);
    step();
    chk("fl_xfer_ins",   pipe_ins,  16'h0370);
    chk("fl_xfer_valid", pipe_valid, 1);
    chk("fl_issue_cnt1", issue_cnt, 3);
    in_valid = 1'b0;

    // 5: flush with empty scoreboard
    do_reset();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idl_state_drain", state,      2);
    chk("idl_done",        flush_done, 1);
    step();
    chk("idl_state_run", state,      0);
    chk("idl_done_off",  flush_done, 0);

    // 6a: reset during STALL
    do_reset();
    in_valid = 1'b1;
    in_ins   = 16'h0250;
    step();
    in_ins = 16'h04D1;
    step();
    chk("rs_state_stall", state, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rs_state_run", state,      0);
    chk("rs_busy",      busy,       0);
    chk("rs_valid",     pipe_valid, 0);
    chk("rs_stall_cnt", stall_cnt,  0);
    settle();
    chk("rs_ready", in_ready, 1);
    step();
    chk("rs_issue_ins", pipe_ins,  16'h04D1);
    chk("rs_issue_cnt", issue_cnt, 1);

    // 6b: issue_cnt wrap with 16 NOP-class transfers
    do_reset();
    in_valid = 1'b1;
    in_ins   = 16'h0600;
    for (int i = 0; i < 15; i++) step();
    chk("wrap_cnt15", issue_cnt, 4'hF);
    step();
    chk("wrap_cnt0",   issue_cnt,  0);
    chk("wrap_ins",    pipe_ins,   16'h0600);
    chk("wrap_valid",  pipe_valid, 1);
    chk("wrap_busy",   busy,       0);
    chk("wrap_stalls", stall_cnt,  0);

    // 6c: ADD R1,R1,R1 chain -> 2 stall cycles per issue, saturating
    do_reset();
    in_valid = 1'b1;
    in_ins   = 16'h0449;
    for (int i = 0; i < 6; i++) step();
    chk("sat_stall6", stall_cnt, 4);
    chk("sat_issue6", issue_cnt, 2);
    for (int i = 0; i < 24; i++) step();
    chk("sat_stall_hold", stall_cnt, 4'hF);
    chk("sat_issue30",    issue_cnt, 4'hA);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
